prefetch_buffer: RTL and testbench

- Instruction prefetch queue sitting directly upstream of the fetch stage, between the instruction memory port and the fetch stage.
- Issues word-aligned fetch addresses and stores the returned 32-bit words as 16-bit parcels in a circular buffer.
- Presents one aligned 32-bit or 16-bit (compressed) instruction per cycle to the fetch stage.
- Flushes and redirects on jump, exception, mret or fence.

---
 rtl/prefetch_buffer_if.sv | 23 ++
 rtl/prefetch_buffer.sv | 130 +++++++++++++
 tb/tb_prefetch_buffer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/prefetch_buffer_if.sv
// Bundle of the prefetch buffer's memory-side and fetch-side signals.
// The buffer uses the master view; the fetch stage / memory model uses the slave view.
interface prefetch_buffer_if;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        jump;
    logic        fence;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] instr;
    logic [31:0] fpc;
    logic        stall;

    modport master (
        input  pc, npc, jump, fence, rdata, ready,
        output instr, fpc, stall
    );

    modport slave (
        output pc, npc, jump, fence, rdata, ready,
        input  instr, fpc, stall
    );
endinterface

// File: rtl/prefetch_buffer.sv
// Instruction prefetch queue: fetches aligned words, stores 16-bit parcels in a
// circular buffer and presents one 16- or 32-bit instruction per cycle.
module prefetch_buffer #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input logic               clk,
    input logic               rst,
    prefetch_buffer_if.master bus
);

    localparam int unsigned     PW        = $clog2(DEPTH);
    localparam logic [PW-1:0]   PTR_ONE   = PW'(1);
    localparam logic [PW:0]     CNT_ZERO  = {(PW+1){1'b0}};
    localparam logic [PW:0]     CNT_ONE   = (PW+1)'(1);
    localparam logic [PW:0]     CNT_TWO   = (PW+1)'(2);
    localparam logic [PW:0]     CNT_DEPTH = (PW+1)'(DEPTH);

    logic [15:0]   buf_r [DEPTH];
    logic [PW-1:0] rptr_r;
    logic [PW-1:0] wptr_r;
    logic [PW:0]   count_r;
    logic [31:0]   fpc_r;
    logic          discard_r;

    logic [15:0]   p0_s;
    logic [15:0]   p1_s;
    logic          head_is32_s;
    logic          head_valid_s;
    logic [31:0]   instr_s;
    logic          flush_s;
    logic [PW:0]   free_s;
    logic          accept_s;
    logic [PW:0]   push_cnt_s;
    logic [PW:0]   cons_cnt_s;
    logic [31:0]   pc_delta_s;

    // Head decode: compressed needs one parcel, a 32-bit instruction needs two
    always_comb begin
        p0_s         = buf_r[rptr_r];
        p1_s         = buf_r[rptr_r + PTR_ONE];
        head_is32_s  = (p0_s[1:0] == 2'b11);
        head_valid_s = 1'b0;
        instr_s      = NOP;
        if ((count_r != CNT_ZERO) && !head_is32_s) begin
            head_valid_s = 1'b1;
            instr_s      = {16'h0000, p0_s};
        end else if (head_is32_s && (count_r >= CNT_TWO)) begin
            head_valid_s = 1'b1;
            instr_s      = {p1_s, p0_s};
        end else begin
            head_valid_s = 1'b0;
            instr_s      = NOP;
        end
    end

    // Write acceptance uses the count before this cycle's consume
    always_comb begin
        flush_s  = bus.jump | bus.fence;
        free_s   = CNT_DEPTH - count_r;
        accept_s = bus.ready && !flush_s && (free_s >= CNT_TWO);
        if (accept_s) begin
            push_cnt_s = discard_r ? CNT_ONE : CNT_TWO;
        end else begin
            push_cnt_s = CNT_ZERO;
        end
    end

    // Consume amount; anything outside the legal 1/2-parcel steps is ignored
    always_comb begin
        pc_delta_s = bus.npc - bus.pc;
        cons_cnt_s = CNT_ZERO;
        if (!flush_s && head_valid_s) begin
            case (pc_delta_s)
                32'd2:   cons_cnt_s = CNT_ONE;
                32'd4:   cons_cnt_s = (count_r >= CNT_TWO) ? CNT_TWO : CNT_ZERO;
                default: cons_cnt_s = CNT_ZERO;
            endcase
        end else begin
            cons_cnt_s = CNT_ZERO;
        end
    end

    // Pointer, occupancy, fetch address and discard-flag state
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_r    <= {PW{1'b0}};
            wptr_r    <= {PW{1'b0}};
            count_r   <= CNT_ZERO;
            fpc_r     <= {RESET_PC[31:2], 2'b00};
            discard_r <= RESET_PC[1];
        end else if (flush_s) begin
            rptr_r    <= {PW{1'b0}};
            wptr_r    <= {PW{1'b0}};
            count_r   <= CNT_ZERO;
            fpc_r     <= {bus.npc[31:2], 2'b00};
            discard_r <= bus.npc[1];
        end else begin
            rptr_r  <= rptr_r + cons_cnt_s[PW-1:0];
            wptr_r  <= wptr_r + push_cnt_s[PW-1:0];
            count_r <= count_r + push_cnt_s - cons_cnt_s;
            if (accept_s) begin
                fpc_r     <= fpc_r + 32'd4;
                discard_r <= 1'b0;
            end
        end
    end

    // Parcel storage; a set discard flag drops the low half of the first word
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_r[i] <= 16'h0000;
            end
        end else if (accept_s) begin
            if (discard_r) begin
                buf_r[wptr_r] <= bus.rdata[31:16];
            end else begin
                buf_r[wptr_r]           <= bus.rdata[15:0];
                buf_r[wptr_r + PTR_ONE] <= bus.rdata[31:16];
            end
        end
    end

    assign bus.instr = instr_s;
    assign bus.stall = ~head_valid_s;
    assign bus.fpc   = fpc_r;

endmodule

// File: tb/tb_prefetch_buffer.sv
// Directed bench for prefetch_buffer: each step drives one cycle of fetch-stage
// and memory inputs, then checks instr/stall/fpc against hand-computed values.
module tb_prefetch_buffer;

    localparam logic [31:0] NOP_I = 32'h0000_0013;

    logic clk;
    logic rst;
    int   pass_cnt  = 0;
    int   fail_cnt  = 0;
    int   total_cnt = 0;

    prefetch_buffer_if bus_i ();

    prefetch_buffer #(
        .DEPTH    (8),
        .RESET_PC (32'h0000_0000),
        .NOP      (NOP_I)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] p, input logic [31:0] n, input logic j,
                         input logic f, input logic r, input logic [31:0] d);
        bus_i.pc    = p;
        bus_i.npc   = n;
        bus_i.jump  = j;
        bus_i.fence = f;
        bus_i.ready = r;
        bus_i.rdata = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e_instr,
                           input logic e_stall, input logic [31:0] e_fpc);
        chk({tag, ".instr"}, bus_i.instr, e_instr);
        chk({tag, ".stall"}, {31'd0, bus_i.stall}, {31'd0, e_stall});
        chk({tag, ".fpc"}, bus_i.fpc, e_fpc);
    endtask

    initial begin
        rst = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk_out("reset", NOP_I, 1'b1, 32'h0);

        // first word: a full 32-bit addi at 0x0
        rst = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0013);
        step();
        chk_out("first_word", 32'h0000_0013, 1'b0, 32'h4);
        drive(32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk_out("consume32", NOP_I, 1'b1, 32'h4);

        // two compressed parcels in one word
        drive(32'h4, 32'h4, 1'b0, 1'b0, 1'b1, 32'h4501_4501);
        step();
        chk_out("cli_a", 32'h0000_4501, 1'b0, 32'h8);
        drive(32'h4, 32'h6, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk_out("cli_b", 32'h0000_4501, 1'b0, 32'h8);
        drive(32'h6, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk_out("cli_empty", NOP_I, 1'b1, 32'h8);

        // 32-bit instruction split across two words
        drive(32'h8, 32'h8, 1'b0, 1'b0, 1'b1, 32'h0013_4501);
        step();
        chk_out("mis_c", 32'h0000_4501, 1'b0, 32'hC);
        drive(32'h8, 32'hA, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk_out("mis_wait", NOP_I, 1'b1, 32'hC);
        drive(32'hA, 32'hA, 1'b0, 1'b0, 1'b1, 32'h0000_0000);
        step();
        chk_out("mis_join", 32'h0000_0013, 1'b0, 32'h10);
        drive(32'hA, 32'hE, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk_out("after_join", 32'h0000_0000, 1'b0, 32'h10);

        // redirect to a halfword target drops the same-cycle response
        drive(32'hE, 32'h102, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        step();
        chk_out("redirect", NOP_I, 1'b1, 32'h100);
        drive(32'h102, 32'h102, 1'b0, 1'b0, 1'b1, 32'hAAAA_4501);
        step();
        chk_out("discard", 32'h0000_AAAA, 1'b0, 32'h104);

        // fill to capacity, then drop and refetch
        drive(32'h102, 32'h200, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        chk_out("full_base", NOP_I, 1'b1, 32'h200);
        for (int i = 0; i < 4; i++) begin
            drive(32'h200, 32'h200, 1'b0, 1'b0, 1'b1, 32'h4501_4501);
            step();
        end
        chk_out("full", 32'h0000_4501, 1'b0, 32'h210);
        drive(32'h200, 32'h200, 1'b0, 1'b0, 1'b1, 32'h4501_4501);
        step();
        chk_out("full_drop", 32'h0000_4501, 1'b0, 32'h210);
        drive(32'h200, 32'h204, 1'b0, 1'b0, 1'b1, 32'h4501_4501);
        step();
        chk_out("drop_precons", 32'h0000_4501, 1'b0, 32'h210);
        drive(32'h204, 32'h204, 1'b0, 1'b0, 1'b1, 32'h4501_4501);
        step();
        chk_out("refetch", 32'h0000_4501, 1'b0, 32'h214);

        // walk pointers round so a 32-bit instruction straddles slot 7 / slot 0
        drive(32'h204, 32'h300, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        chk_out("wrap_base", NOP_I, 1'b1, 32'h300);
        drive(32'h300, 32'h300, 1'b0, 1'b0, 1'b1, 32'h4501_4501);
        step();
        chk_out("w1", 32'h0000_4501, 1'b0, 32'h304);
        drive(32'h300, 32'h304, 1'b0, 1'b0, 1'b1, 32'h4501_4501);
        step();
        chk_out("w2", 32'h0000_4501, 1'b0, 32'h308);
        drive(32'h304, 32'h308, 1'b0, 1'b0, 1'b1, 32'h4501_4501);
        step();
        chk_out("w3", 32'h0000_4501, 1'b0, 32'h30C);
        drive(32'h308, 32'h30C, 1'b0, 1'b0, 1'b1, 32'h0093_4501);
        step();
        chk_out("w4", 32'h0000_4501, 1'b0, 32'h310);
        drive(32'h30C, 32'h30E, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk_out("straddle_wait", NOP_I, 1'b1, 32'h310);
        drive(32'h30E, 32'h312, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk_out("violation_ignored", NOP_I, 1'b1, 32'h310);
        drive(32'h30E, 32'h30E, 1'b0, 1'b0, 1'b1, 32'h4501_0050);
        step();
        chk_out("straddle", 32'h0050_0093, 1'b0, 32'h314);
        drive(32'h30E, 32'h312, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk_out("post_wrap", 32'h0000_4501, 1'b0, 32'h314);

        // fence.i mid-stream
        drive(32'h312, 32'h40E, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        step();
        chk_out("fence", NOP_I, 1'b1, 32'h40C);
        drive(32'h40E, 32'h40E, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        step();
        chk_out("fence_refill", 32'h0000_1234, 1'b0, 32'h410);

        // reset with a response in flight
        rst = 1'b1;
        drive(32'h40E, 32'h40E, 1'b0, 1'b0, 1'b1, 32'h0000_0013);
        step();
        chk_out("reset_mid", NOP_I, 1'b1, 32'h0);
        rst = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk_out("reset_idle", NOP_I, 1'b1, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
